// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, default widths
// and the legal-latency check used at elaboration.
package dmem_responder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  function automatic bit latencyOk(input int lat);
    return (lat >= 1) && (lat <= 15);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, read-before-write, no reset on contents.
module dmem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     din,
  output logic [DATA_W-1:0]     dout
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request in flight, fixed latency,
// one-cycle response pulse and a pipeline stall while the access is pending.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              stall
);

  if (!latencyOk(LATENCY)) begin : gLatChk
    $error("dmem_responder: LATENCY must be in 1..15");
  end

  typedef struct packed {
    logic                  wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     wdata;
  } req_t;

  logic [1:0]        state;
  logic [3:0]        cnt;
  req_t              lat;
  req_t              cur;
  logic [DATA_W-1:0] rdataHold;
  logic [DATA_W-1:0] ramDout;
  logic              accept;
  logic              commit;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{req_addr[ADDR_W-1:DEPTH_LOG2+1], req_addr[0]};

  // With LATENCY==1 the commit edge is also the accept edge, so the RAM sees the live inputs.
  always_comb begin
    cur = lat;
    if (state == ST_IDLE) begin
      cur.wr    = req_wr;
      cur.idx   = req_addr[DEPTH_LOG2:1];
      cur.wdata = req_wdata;
    end
  end

  assign accept = (state == ST_IDLE) && req_valid;
  assign commit = rst && (((state == ST_WAIT) && (cnt == 4'd1)) ||
                          (accept && (LATENCY == 1)));

  dmem_array #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) uArray (
    .clk (clk),
    .we  (commit && cur.wr),
    .addr(cur.idx),
    .din (cur.wdata),
    .dout(ramDout)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign stall      = accept || (state == ST_WAIT);
  // The word read on the commit edge is presented in RESP, then held until the next response.
  assign resp_rdata = resp_valid ? (lat.wr ? '0 : ramDout) : rdataHold;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat       <= '0;
      rdataHold <= '0;
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          lat   <= cur;
          cnt   <= 4'(LATENCY - 1);
          state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 4'd1) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          rdataHold <= resp_rdata;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
